// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: width derivations and the MAC state type.
package alu_pkg;

  // MAC sequencing: collecting terms, or holding a finished result.
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Accumulator width that cannot overflow for `length` products of size x size.
  function automatic int unsigned acc_width(input int unsigned size, input int unsigned length);
    return 2 * size + $clog2(length);
  endfunction

  // Counter width able to represent 0..length.
  function automatic int unsigned cnt_width(input int unsigned length);
    return $clog2(length + 1);
  endfunction

endpackage

// File: rtl/tree_multiplier.sv
// Combinational unsigned multiplier built from shifted partial products.
// Ports: a, b (SIZE-bit unsigned operands) -> p (2*SIZE-bit product).
module tree_multiplier #(
  parameter int unsigned SIZE = 4
) (
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] p
);

  localparam int unsigned PW = 2 * SIZE;

  logic [PW-1:0] pp [SIZE];

  // One partial product per multiplier bit.
  always_comb begin
    for (int i = 0; i < int'(SIZE); i++) begin
      pp[i] = b[i] ? (PW'(a) << i) : '0;
    end
  end

  // Reduce the partial products; synthesis balances the adder structure.
  always_comb begin
    p = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      p = p + pp[i];
    end
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sequential multiply-accumulate: sums up to LENGTH products a*b per vector
// and presents the completed sum on a valid/ready output port.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/a/b/in_last term
// input; out_valid/out_ready/out_sum/out_terms result output.
module dot_product_accumulator
  import alu_pkg::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned LENGTH    = 4,
  parameter int unsigned ACC_WIDTH = acc_width(SIZE, LENGTH),
  parameter int unsigned CNT_WIDTH = cnt_width(LENGTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      a,
  input  logic [SIZE-1:0]      b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_terms
);

  localparam int unsigned PW    = 2 * SIZE;
  localparam int unsigned EXT_W = (ACC_WIDTH > PW) ? ACC_WIDTH : PW;

  state_t               state, state_n;
  logic [ACC_WIDTH-1:0] acc, acc_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic                 out_valid_n;
  logic [ACC_WIDTH-1:0] out_sum_n;
  logic [CNT_WIDTH-1:0] out_terms_n;

  logic [PW-1:0]        p;
  logic [EXT_W-1:0]     p_ext;
  logic [ACC_WIDTH-1:0] p_acc;
  logic [ACC_WIDTH-1:0] sum_c;
  logic                 accept;
  logic                 final_term;

  tree_multiplier #(.SIZE(SIZE)) u_mul (
    .a (a),
    .b (b),
    .p (p)
  );

  // Zero-extend (or wrap, if ACC_WIDTH is narrowed) the product.
  assign p_ext = EXT_W'(p);
  assign p_acc = p_ext[ACC_WIDTH-1:0];
  assign sum_c = acc + p_acc;

  // In HOLD a new term can enter only alongside the result handoff.
  assign in_ready   = rst_n & ((state == ACC) | out_ready);
  assign accept     = in_valid & in_ready;
  // cnt is zero in HOLD, so this also covers the handoff term (LENGTH=1).
  assign final_term = (cnt == CNT_WIDTH'(LENGTH - 1)) | in_last;

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_terms <= '0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_valid <= out_valid_n;
      out_sum   <= out_sum_n;
      out_terms <= out_terms_n;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    out_valid_n = out_valid;
    out_sum_n   = out_sum;
    out_terms_n = out_terms;

    case (state)
      ACC:  ;
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ACC;
        end
      end
      default: state_n = ACC;
    endcase

    // acc is zero in HOLD, so sum_c is just p for a handoff term.
    if (accept) begin
      if (final_term) begin
        out_sum_n   = sum_c;
        out_terms_n = cnt + CNT_WIDTH'(1);
        out_valid_n = 1'b1;
        acc_n       = '0;
        cnt_n       = '0;
        state_n     = HOLD;
      end else begin
        acc_n = sum_c;
        cnt_n = cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench for dot_product_accumulator (SIZE=4, LENGTH=4).
module tb_dot_product_accumulator;

  localparam int unsigned SIZE      = 4;
  localparam int unsigned LENGTH    = 4;
  localparam int unsigned ACC_WIDTH = 10;
  localparam int unsigned CNT_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [SIZE-1:0]      a;
  logic [SIZE-1:0]      b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_terms;

  dot_product_accumulator #(
    .SIZE      (SIZE),
    .LENGTH    (LENGTH),
    .ACC_WIDTH (ACC_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_terms (out_terms)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: partial vector as a running sum/count, finished results as a queue.
  int m_sum = 0;
  int m_cnt = 0;
  int pend_sum[$];
  int pend_terms[$];
  int log_sum[$];
  int log_terms[$];
  bit m_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sum = 0;
      m_cnt = 0;
      pend_sum.delete();
      pend_terms.delete();
    end else begin
      m_rdy = (pend_sum.size() == 0) || out_ready;
      if (pend_sum.size() != 0 && out_ready) begin
        void'(pend_sum.pop_front());
        void'(pend_terms.pop_front());
      end
      if (in_valid && m_rdy) begin
        m_sum += int'(a) * int'(b);
        m_cnt++;
        if (m_cnt == int'(LENGTH) || in_last) begin
          pend_sum.push_back(m_sum % (1 << ACC_WIDTH));
          pend_terms.push_back(m_cnt);
          log_sum.push_back(m_sum % (1 << ACC_WIDTH));
          log_terms.push_back(m_cnt);
          m_sum = 0;
          m_cnt = 0;
        end
      end
    end
  end

  // Every cycle, mid-period: outputs against the model.
  always @(negedge clk) begin
    if (checking) begin
      chk("out_valid", longint'(out_valid), longint'(pend_sum.size() != 0));
      chk("in_ready", longint'(in_ready),
          longint'(rst_n && (pend_sum.size() == 0 || out_ready)));
      if (pend_sum.size() != 0) begin
        chk("out_sum", longint'(out_sum), longint'(pend_sum[0]));
        chk("out_terms", longint'(out_terms), longint'(pend_terms[0]));
      end
    end
  end

  // Present one term and hold it until accepted; returns just after the accepting edge.
  task automatic term(input int x, input int y, input bit last);
    bit ok = 1'b0;
    a        = SIZE'(x);
    b        = SIZE'(y);
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_sum[10]   = '{150, 900, 0, 78, 4, 16, 9, 16, 25, 4};
    int exp_terms[10] = '{4, 4, 4, 2, 4, 4, 4, 1, 1, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_out_terms", longint'(out_terms), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    rst_n = 1'b1;
    idle(1);

    // 1: back-to-back full vector.
    term(15, 1, 0); term(15, 2, 0); term(15, 3, 0);
    chk("t1_not_yet_valid", longint'(out_valid), 0);
    term(15, 4, 0);
    chk("t1_valid", longint'(out_valid), 1);
    chk("t1_sum", longint'(out_sum), 150);
    chk("t1_terms", longint'(out_terms), 4);

    // 2: maximum products, then zero products.
    for (int i = 0; i < 4; i++) term(15, 15, 0);
    for (int i = 0; i < 4; i++) term(15, 0, 0);
    idle(2);

    // 3: early close with in_last, then a fresh vector.
    term(3, 5, 0); term(7, 9, 1);
    chk("t3_sum", longint'(out_sum), 78);
    chk("t3_terms", longint'(out_terms), 2);
    for (int i = 0; i < 4; i++) term(1, 1, 0);
    idle(2);

    // 4: backpressure, then handoff with a simultaneous new term.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) term(2, 2, 0);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("t4_hold_valid", longint'(out_valid), 1);
      chk("t4_hold_sum", longint'(out_sum), 16);
      chk("t4_hold_ready", longint'(in_ready), 0);
    end
    out_ready = 1'b1;
    term(2, 3, 0);
    chk("t4_handoff_valid", longint'(out_valid), 0);
    for (int i = 0; i < 3; i++) term(1, 1, 0);
    chk("t4_next_sum", longint'(out_sum), 9);
    idle(2);

    // 5: handoff where the new term is itself final.
    out_ready = 1'b0;
    term(4, 4, 1);
    idle(1);
    out_ready = 1'b1;
    term(5, 5, 1);
    chk("t5_valid", longint'(out_valid), 1);
    chk("t5_sum", longint'(out_sum), 25);
    chk("t5_terms", longint'(out_terms), 1);
    idle(2);

    // 6: reset mid-vector.
    term(15, 15, 0); term(15, 15, 0);
    rst_n = 1'b0;
    idle(1);
    chk("t6_rst_valid", longint'(out_valid), 0);
    chk("t6_rst_sum", longint'(out_sum), 0);
    chk("t6_rst_ready", longint'(in_ready), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) term(1, 1, 0);
    chk("t6_sum", longint'(out_sum), 4);
    idle(3);

    // Pin the model's result log to hand-computed values.
    chk("log_count", longint'(log_sum.size()), 10);
    for (int i = 0; i < 10 && i < log_sum.size(); i++) begin
      chk("log_sum", longint'(log_sum[i]), longint'(exp_sum[i]));
      chk("log_terms", longint'(log_terms[i]), longint'(exp_terms[i]));
    end

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
